// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle control unit and PC sequencer for the yIF/yID/yEX/yDM/yWB
// datapath. Latches each instruction, decodes it and walks it through
// FETCH/DECODE/EXEC/MEM/WB. It also handles the data-memory wait/timeout,
// traps illegal instructions and counts retired instructions.
module y_mc_ctrl #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 'h28,
  parameter int unsigned          TMO_W    = 4,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  PCp4,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  jTarget,
  output logic [XLEN-1:0]  PC,
  output logic [31:0]      ir,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       Mem2Reg,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  // Last wait count before giving up: the (2^TMO_W-1)th low cycle traps.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_e           r_state;
  state_e           w_next;
  logic [XLEN-1:0]  r_pc;
  logic [31:0]      r_ir;
  logic             r_trap;
  logic [CNT_W-1:0] r_retired;
  logic [TMO_W-1:0] r_tmo;

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic             w_isR;
  logic             w_isI;
  logic             w_isLw;
  logic             w_isSw;
  logic             w_isBeq;
  logic             w_isJal;
  logic             w_legal;
  logic [2:0]       w_aluOp;
  logic             w_aluSrc;
  logic             w_retire;
  logic [XLEN-1:0]  w_pcNext;

  assign w_opcode = r_ir[6:0];
  assign w_f3     = r_ir[14:12];
  assign w_f7     = r_ir[31:25];

  // Decode the latched instruction into class, legality, ALU op and operand select.
  always_comb begin
    w_isR    = 1'b0;
    w_isI    = 1'b0;
    w_isLw   = 1'b0;
    w_isSw   = 1'b0;
    w_isBeq  = 1'b0;
    w_isJal  = 1'b0;
    w_legal  = 1'b0;
    w_aluOp  = OP_ADD;
    w_aluSrc = 1'b0;
    case (w_opcode)
      7'h33: begin
        w_isR = 1'b1;
        case (w_f3)
          3'b000: begin
            if (w_f7 == 7'h00) begin
              w_legal = 1'b1;
              w_aluOp = OP_ADD;
            end else if (w_f7 == 7'h20) begin
              w_legal = 1'b1;
              w_aluOp = OP_SUB;
            end
          end
          3'b111: begin
            w_legal = (w_f7 == 7'h00);
            w_aluOp = OP_AND;
          end
          3'b110: begin
            w_legal = (w_f7 == 7'h00);
            w_aluOp = OP_OR;
          end
          3'b010: begin
            w_legal = (w_f7 == 7'h00);
            w_aluOp = OP_SLT;
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'h13: begin
        w_isI    = 1'b1;
        w_aluSrc = 1'b1;
        case (w_f3)
          3'b000: begin
            w_legal = 1'b1;
            w_aluOp = OP_ADD;
          end
          3'b111: begin
            w_legal = 1'b1;
            w_aluOp = OP_AND;
          end
          3'b110: begin
            w_legal = 1'b1;
            w_aluOp = OP_OR;
          end
          3'b010: begin
            w_legal = 1'b1;
            w_aluOp = OP_SLT;
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'h03: begin
        w_isLw   = 1'b1;
        w_legal  = 1'b1;
        w_aluSrc = 1'b1;
      end
      7'h23: begin
        w_isSw   = 1'b1;
        w_legal  = 1'b1;
        w_aluSrc = 1'b1;
      end
      7'h63: begin
        w_isBeq = 1'b1;
        w_legal = (w_f3 == 3'b000);
        w_aluOp = OP_SUB;
      end
      7'h6F: begin
        w_isJal  = 1'b1;
        w_legal  = 1'b1;
        w_aluSrc = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // State register; reset drops straight back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, including the memory wait timeout and the trap sink.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_isLw || w_isSw) begin
          w_next = S_MEM;
        end else if (w_isBeq) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next = w_isLw ? S_WB : S_FETCH;
        end else if (r_tmo == TMO_LAST) begin
          w_next = S_TRAP;
        end
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // An instruction retires on the cycle it hands the PC its successor.
  always_comb begin
    w_retire = 1'b0;
    w_pcNext = PCp4;
    case (r_state)
      S_EXEC: begin
        w_retire = w_isBeq;
        w_pcNext = zero ? branch : PCp4;
      end
      S_MEM: begin
        w_retire = w_isSw && mem_ready;
      end
      S_WB: begin
        w_retire = 1'b1;
        w_pcNext = w_isJal ? jTarget : PCp4;
      end
      default: w_retire = 1'b0;
    endcase
  end

  // Architectural registers: instruction latch, PC, retire count, sticky trap, wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0;
      r_trap    <= 1'b0;
      r_retired <= '0;
      r_tmo     <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_ir <= ins;
      end
      if (w_retire) begin
        r_pc      <= w_pcNext;
        r_retired <= r_retired + CNT_W'(1);
      end
      if (w_next == S_TRAP) begin
        r_trap <= 1'b1;
      end
      if (r_state == S_MEM) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= '0;
      end
    end
  end

  // Moore control outputs from state and latched instruction only.
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = OP_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 2'b00;
    case (r_state)
      S_EXEC: begin
        op     = w_aluOp;
        ALUSrc = w_aluSrc;
      end
      S_MEM: begin
        op       = w_aluOp;
        ALUSrc   = w_aluSrc;
        MemRead  = w_isLw;
        MemWrite = w_isSw;
      end
      S_WB: begin
        op       = w_aluOp;
        ALUSrc   = w_aluSrc;
        RegWrite = 1'b1;
        if (w_isLw) begin
          Mem2Reg = 2'b01;
        end else if (w_isJal) begin
          Mem2Reg = 2'b10;
        end
      end
      default: RegWrite = 1'b0;
    endcase
  end

  assign PC      = r_pc;
  assign ir      = r_ir;
  assign trap    = r_trap;
  assign retired = r_retired;
  assign state   = r_state;

endmodule
